td4_core: RTL and testbench
===========================

# td4_core

TD4 4-bit processor core: the consumer of the program-ROM interface. Each enabled clock it drives a 4-bit instruction address, takes the 8-bit instruction word back combinationally in the same cycle, and executes it. It holds registers A, B, the output latch, the PC and the carry flag. It sits between the program ROM and the board-level I/O: switches feed `in_port`, LEDs are driven from `out_port`.

## Interface
Parameters:
- none; all widths are fixed by the TD4 architecture (4-bit data, 4-bit address, 8-bit instruction).

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  step enable; the core executes one instruction on each rising `clk` edge where `en`=1.
- `adr`  out  4  program address to the ROM; equals the PC register.
- `qd`  in  8  instruction from the ROM: [7:4] opcode, [3:0] immediate `im`.
- `in_port`  in  4  external input; sampled only by the IN instructions.
- `out_port`  out  4  output latch.
- `carry`  out  1  carry flag, exposed for debug and the LED display.

## Operation
- Every instruction computes `alu = src + im`, with a 5-bit result.
  - Bits [3:0] are written to the destination, if there is one.
  - Bit 4 is loaded into the carry flag on every executed instruction, with no exceptions.
- Decode of `qd[7:4]`, given as src → dst:
  - 0000 ADD A,im: A → A
  - 0101 ADD B,im: B → B
  - 0011 MOV A,im: 0 → A
  - 0111 MOV B,im: 0 → B
  - 0001 MOV A,B: B → A
  - 0100 MOV B,A: A → B
  - 0010 IN A: in_port → A
  - 0110 IN B: in_port → B
  - 1001 OUT B: B → out_port
  - 1011 OUT im: 0 → out_port
  - 1111 JMP im: 0 → PC
  - 1110 JNC im: 0 → PC, only when the carry flag was 0 before this instruction
- All other opcodes are NOP:
  - src is 0, so the carry flag is loaded with 0 (im ≤ 15 never carries).
  - No register is written.
- PC update:
  - JMP, and JNC with the prior carry at 0: PC ← alu[3:0], which equals `im`.
  - Otherwise: PC ← PC+1, wrapping from 15 to 0.
- An instruction whose src and dst are the same register (ADD A, ADD B) reads the value from before the edge.
- Reset values, applied asynchronously while `rst`=0: A=0, B=0, out_port=0, PC=0 (so adr=0), carry=0.

## Timing
- The ROM is combinational, so `qd` is valid in the same cycle that `adr` is presented.
- An instruction executes in 1 cycle: every state update happens on the single rising edge with `en`=1.
- Latency:
  - `out_port` and `carry` change on the edge that executes the instruction.
  - `adr` shows the next PC immediately after that edge.
- With `en`=0, all state holds and `in_port` is ignored.
- `in_port` is sampled on the executing edge. It is assumed synchronous to `clk`; synchronization belongs to the board top.
- Reset asserted mid-program clears all state immediately, without waiting for a clock edge.
  - The first instruction after reset release is fetched from address 0.
  - It executes on the first edge with `rst`=1 and `en`=1.

## Structure
- Package `td4_pkg` holds:
  - the opcode localparams (OP_ADD_A, OP_MOV_A_B, OP_JNC, ...);
  - a source-select enum (SRC_ZERO, SRC_A, SRC_B, SRC_IN);
  - a destination-select enum (DST_NONE, DST_A, DST_B, DST_OUT, DST_PC).
- Sub-module `td4_decode` is a purely combinational opcode-to-control decoder. It produces src, dst, and is_jnc.
- The register file, adder and PC live in `td4_core`.

## Test plan
- Reset then run: ROM {0: 0011_0101, 1: 1001_0000, 2: 1111_0001}.
  - Sequence: MOV A,5; OUT B; JMP 1.
  - Required: A=5, out_port=0; adr sequence 0,1,2,1,2…; carry stays 0.
- Carry and JNC: ROM {0: 0011_1110, 1: 0000_0011, 2: 1110_0000, 3: 1011_1111}.
  - Sequence: MOV A,14; ADD A,3; JNC 0; OUT 15.
  - Required: A=1 and carry=1 after ADD; JNC falls through to 3; out_port=15; carry=0 after OUT.
- JNC taken: ROM {0: 0011_0001, 1: 1110_0101}.
  - Required: carry=0 after MOV, so adr goes to 5.
- IN/MOV/OUT: in_port=9.
  - Sequence: IN B; MOV A,B; ADD A,1; MOV B,A; OUT B.
  - Required: out_port=10.
- PC wrap: ROM filled with NOP (1000_0000).
  - Required: adr counts 0..15, then 0.
- Enable and async reset:
  - Hold `en`=0 for 5 cycles: adr and all registers are unchanged.
  - Pulse `rst` low between clock edges while A=7: A, B, out_port, adr and carry read 0 before the next edge.

Source files
------------

// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 4-bit core: opcodes, operand select enums
// and the 5-bit ALU helper.
package td4_pkg;

  localparam logic [3:0] OP_ADD_A   = 4'b0000;
  localparam logic [3:0] OP_MOV_A_B = 4'b0001;
  localparam logic [3:0] OP_IN_A    = 4'b0010;
  localparam logic [3:0] OP_MOV_A   = 4'b0011;
  localparam logic [3:0] OP_MOV_B_A = 4'b0100;
  localparam logic [3:0] OP_ADD_B   = 4'b0101;
  localparam logic [3:0] OP_IN_B    = 4'b0110;
  localparam logic [3:0] OP_MOV_B   = 4'b0111;
  localparam logic [3:0] OP_OUT_B   = 4'b1001;
  localparam logic [3:0] OP_OUT_IM  = 4'b1011;
  localparam logic [3:0] OP_JNC     = 4'b1110;
  localparam logic [3:0] OP_JMP     = 4'b1111;

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_A,
    SRC_B,
    SRC_IN
  } src_sel_e;

  typedef enum logic [2:0] {
    DST_NONE,
    DST_A,
    DST_B,
    DST_OUT,
    DST_PC
  } dst_sel_e;

  // Bit 4 of the result is the carry out.
  function automatic logic [4:0] alu_add(input logic [3:0] src, input logic [3:0] im);
    return {1'b0, src} + {1'b0, im};
  endfunction

endpackage

// File: rtl/td4_decode.sv
// Combinational opcode decoder: maps the upper instruction nibble to the
// ALU source, the write destination and the conditional-jump flag.
module td4_decode
  import td4_pkg::*;
(
  input  logic [3:0] i_opcode,
  output src_sel_e   o_src,
  output dst_sel_e   o_dst,
  output logic       o_is_jnc
);

  // Unlisted opcodes fall through as NOP: zero source, nothing written.
  always_comb begin
    o_src    = SRC_ZERO;
    o_dst    = DST_NONE;
    o_is_jnc = 1'b0;
    case (i_opcode)
      OP_ADD_A:   begin o_src = SRC_A;    o_dst = DST_A;   end
      OP_ADD_B:   begin o_src = SRC_B;    o_dst = DST_B;   end
      OP_MOV_A:   begin o_src = SRC_ZERO; o_dst = DST_A;   end
      OP_MOV_B:   begin o_src = SRC_ZERO; o_dst = DST_B;   end
      OP_MOV_A_B: begin o_src = SRC_B;    o_dst = DST_A;   end
      OP_MOV_B_A: begin o_src = SRC_A;    o_dst = DST_B;   end
      OP_IN_A:    begin o_src = SRC_IN;   o_dst = DST_A;   end
      OP_IN_B:    begin o_src = SRC_IN;   o_dst = DST_B;   end
      OP_OUT_B:   begin o_src = SRC_B;    o_dst = DST_OUT; end
      OP_OUT_IM:  begin o_src = SRC_ZERO; o_dst = DST_OUT; end
      OP_JMP:     begin o_src = SRC_ZERO; o_dst = DST_PC;  end
      OP_JNC: begin
        o_src    = SRC_ZERO;
        o_dst    = DST_PC;
        o_is_jnc = 1'b1;
      end
      default: begin
        o_src    = SRC_ZERO;
        o_dst    = DST_NONE;
        o_is_jnc = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/td4_core.sv
// TD4 4-bit processor core: fetches from a combinational ROM at adr and
// executes one instruction per enabled clock edge.
module td4_core
  import td4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [3:0] adr,
  input  logic [7:0] qd,
  input  logic [3:0] in_port,
  output logic [3:0] out_port,
  output logic       carry
);

  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [3:0] r_out;
  logic [3:0] r_pc;
  logic       r_carry;

  logic [3:0] w_opcode;
  logic [3:0] w_im;
  src_sel_e   w_src;
  dst_sel_e   w_dst;
  logic       w_is_jnc;
  logic [3:0] w_src_val;
  logic [4:0] w_alu;
  logic       w_jump;

  assign w_opcode = qd[7:4];
  assign w_im     = qd[3:0];

  td4_decode u_decode (
    .i_opcode (w_opcode),
    .o_src    (w_src),
    .o_dst    (w_dst),
    .o_is_jnc (w_is_jnc)
  );

  always_comb begin
    w_src_val = 4'd0;
    case (w_src)
      SRC_A:   w_src_val = r_a;
      SRC_B:   w_src_val = r_b;
      SRC_IN:  w_src_val = in_port;
      default: w_src_val = 4'd0;
    endcase
  end

  assign w_alu = alu_add(w_src_val, w_im);

  // JNC looks at the carry from before this instruction, not the new one.
  assign w_jump = (w_dst == DST_PC) && (!w_is_jnc || !r_carry);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a     <= 4'd0;
      r_b     <= 4'd0;
      r_out   <= 4'd0;
      r_pc    <= 4'd0;
      r_carry <= 1'b0;
    end else if (en) begin
      r_carry <= w_alu[4];
      case (w_dst)
        DST_A:   r_a   <= w_alu[3:0];
        DST_B:   r_b   <= w_alu[3:0];
        DST_OUT: r_out <= w_alu[3:0];
        default: ;
      endcase
      r_pc <= w_jump ? w_alu[3:0] : r_pc + 4'd1;
    end
  end

  assign adr      = r_pc;
  assign out_port = r_out;
  assign carry    = r_carry;

endmodule

// File: tb/tb_td4_core.sv
// Directed, table-driven bench for td4_core with a behavioural ROM.
module tb_td4_core;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] adr;
  logic [7:0] qd;
  logic [3:0] in_port;
  logic [3:0] out_port;
  logic       carry;

  logic [7:0] rom [16];

  int nCheck;
  int nPass;

  typedef struct {
    logic       en;
    logic [3:0] inp;
    logic [3:0] adr;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] outp;
    logic       c;
  } vec_t;

  vec_t vecs[$];

  td4_core dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .adr      (adr),
    .qd       (qd),
    .in_port  (in_port),
    .out_port (out_port),
    .carry    (carry)
  );

  assign qd = rom[adr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    nCheck++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic checkState(input string tag, input logic [3:0] eAdr, input logic [3:0] eA,
                            input logic [3:0] eB, input logic [3:0] eOut, input logic eC);
    checkOutput({tag, ".adr"}, adr, eAdr);
    checkOutput({tag, ".A"}, dut.r_a, eA);
    checkOutput({tag, ".B"}, dut.r_b, eB);
    checkOutput({tag, ".out_port"}, out_port, eOut);
    checkOutput({tag, ".carry"}, {3'b000, carry}, {3'b000, eC});
  endtask

  task automatic loadNops();
    for (int i = 0; i < 16; i++) rom[i] = 8'b1000_0000;
  endtask

  task automatic addVec(input logic e, input logic [3:0] inp, input logic [3:0] eAdr,
                        input logic [3:0] eA, input logic [3:0] eB, input logic [3:0] eOut,
                        input logic eC);
    vec_t v;
    v.en = e; v.inp = inp; v.adr = eAdr; v.a = eA; v.b = eB; v.outp = eOut; v.c = eC;
    vecs.push_back(v);
  endtask

  task automatic resetCore(input string tag);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    @(negedge clk);
    checkState({tag, ".reset"}, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    rst = 1'b1;
  endtask

  // Drive each record at the falling edge, check state just after the rising edge.
  task automatic applyStimulus(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      en = vecs[i].en;
      in_port = vecs[i].inp;
      @(posedge clk);
      #1;
      checkState($sformatf("%s.step%0d", tag, i), vecs[i].adr, vecs[i].a, vecs[i].b,
                 vecs[i].outp, vecs[i].c);
    end
    vecs.delete();
  endtask

  initial begin
    nCheck = 0;
    nPass = 0;
    rst = 1'b0;
    en = 1'b0;
    in_port = 4'd0;
    loadNops();

    // MOV A,5; OUT B; JMP 1
    rom[0] = 8'b0011_0101;
    rom[1] = 8'b1001_0000;
    rom[2] = 8'b1111_0001;
    resetCore("loop");
    addVec(1, 0, 4'd1, 4'd5, 4'd0, 4'd0, 0);
    addVec(1, 0, 4'd2, 4'd5, 4'd0, 4'd0, 0);
    addVec(1, 0, 4'd1, 4'd5, 4'd0, 4'd0, 0);
    addVec(1, 0, 4'd2, 4'd5, 4'd0, 4'd0, 0);
    addVec(1, 0, 4'd1, 4'd5, 4'd0, 4'd0, 0);
    applyStimulus("loop");

    // MOV A,14; ADD A,3; JNC 0 (not taken); OUT 15; NOP
    loadNops();
    rom[0] = 8'b0011_1110;
    rom[1] = 8'b0000_0011;
    rom[2] = 8'b1110_0000;
    rom[3] = 8'b1011_1111;
    resetCore("carry");
    addVec(1, 0, 4'd1, 4'd14, 4'd0, 4'd0, 0);
    addVec(1, 0, 4'd2, 4'd1, 4'd0, 4'd0, 1);
    addVec(1, 0, 4'd3, 4'd1, 4'd0, 4'd0, 0);
    addVec(1, 0, 4'd4, 4'd1, 4'd0, 4'd15, 0);
    addVec(1, 0, 4'd5, 4'd1, 4'd0, 4'd15, 0);
    applyStimulus("carry");

    // MOV A,1; JNC 5 (taken)
    loadNops();
    rom[0] = 8'b0011_0001;
    rom[1] = 8'b1110_0101;
    resetCore("jnc");
    addVec(1, 0, 4'd1, 4'd1, 4'd0, 4'd0, 0);
    addVec(1, 0, 4'd5, 4'd1, 4'd0, 4'd0, 0);
    applyStimulus("jnc");

    // IN B; MOV A,B; ADD A,1; MOV B,A; OUT B with in_port=9
    loadNops();
    rom[0] = 8'b0110_0000;
    rom[1] = 8'b0001_0000;
    rom[2] = 8'b0000_0001;
    rom[3] = 8'b0100_0000;
    rom[4] = 8'b1001_0000;
    resetCore("io");
    addVec(1, 9, 4'd1, 4'd0, 4'd9, 4'd0, 0);
    addVec(1, 9, 4'd2, 4'd9, 4'd9, 4'd0, 0);
    addVec(1, 9, 4'd3, 4'd10, 4'd9, 4'd0, 0);
    addVec(1, 9, 4'd4, 4'd10, 4'd10, 4'd0, 0);
    addVec(1, 9, 4'd5, 4'd10, 4'd10, 4'd10, 0);
    applyStimulus("io");

    // All NOPs: PC walks 1..15 then wraps to 0
    loadNops();
    resetCore("wrap");
    for (int i = 1; i <= 16; i++) addVec(1, 0, 4'(i), 4'd0, 4'd0, 4'd0, 0);
    applyStimulus("wrap");

    // MOV A,7; ADD B,15; OUT B; ADD B,15 (carry); then en=0 hold with in_port wiggling
    loadNops();
    rom[0] = 8'b0011_0111;
    rom[1] = 8'b0101_1111;
    rom[2] = 8'b1001_0000;
    rom[3] = 8'b0101_1111;
    rom[4] = 8'b0110_0000;
    resetCore("hold");
    addVec(1, 0, 4'd1, 4'd7, 4'd0, 4'd0, 0);
    addVec(1, 0, 4'd2, 4'd7, 4'd15, 4'd0, 0);
    addVec(1, 0, 4'd3, 4'd7, 4'd15, 4'd15, 0);
    addVec(1, 0, 4'd4, 4'd7, 4'd14, 4'd15, 1);
    for (int i = 0; i < 5; i++) addVec(0, 4'(5 + i), 4'd4, 4'd7, 4'd14, 4'd15, 1);
    applyStimulus("hold");

    // Async reset between edges, then first instruction comes from address 0
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkState("async", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    #1;
    rst = 1'b1;
    addVec(1, 0, 4'd1, 4'd7, 4'd0, 4'd0, 0);
    addVec(1, 0, 4'd2, 4'd7, 4'd15, 4'd0, 0);
    applyStimulus("after");

    $display("%0d/%0d checks passed", nPass, nCheck);
    $finish;
  end

endmodule
